// File: rtl/cn_lut_pkg.sv
// Shared page-controller types and derived page geometry for the CN IB-LUT.
package cn_lut_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_DRAIN = 2'd2
    } page_state_t;

    // Address bits within one page once the page-select bit is removed.
    function automatic int page_aw(input int entry_addr, input int frame_num);
        return entry_addr - $clog2(frame_num);
    endfunction

    function automatic int page_depth(input int entry_addr, input int frame_num);
        return 2 ** page_aw(entry_addr, frame_num);
    endfunction

endpackage

// File: rtl/cn_lut_page_ctrl.sv
// Ping-pong LUT page loader: registered write port one cycle after each handshake, swap ack two cycles after last beat.
// Backpressure: in_ready drops once the shadow page is full and stays low until the post-swap read drain completes.
module cn_lut_page_ctrl
    import cn_lut_pkg::*;
#(
    parameter int LUT_PORT_SIZE   = 2,
    parameter int ENTRY_ADDR      = 4,
    parameter int MULTI_FRAME_NUM = 2,
    parameter int PIPE_DEPTH      = 2
) (
    input  logic                                             sys_clk,
    input  logic                                             rst,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [LUT_PORT_SIZE-1:0]                         in_bank0,
    input  logic [LUT_PORT_SIZE-1:0]                         in_bank1,
    input  logic                                             swap_req,
    output logic                                             swap_ack,
    output logic                                             shadow_valid,
    output logic [LUT_PORT_SIZE-1:0]                         lut_in_bank0,
    output logic [LUT_PORT_SIZE-1:0]                         lut_in_bank1,
    output logic [ENTRY_ADDR-$clog2(MULTI_FRAME_NUM)-1:0]    page_write_addr,
    output logic                                             write_addr_offset,
    output logic                                             we,
    output logic                                             read_addr_offset
);

    localparam int PAGE_AW = page_aw(ENTRY_ADDR, MULTI_FRAME_NUM);
    localparam int DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 1);

    page_state_t          state;
    page_state_t          next_state;
    logic [PAGE_AW-1:0]   wr_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 hs;

    assign hs                = in_valid & in_ready;
    assign write_addr_offset = ~read_addr_offset;

    always_comb begin
        next_state = state;
        case (state)
            ST_LOAD:  if (hs && (wr_cnt == {PAGE_AW{1'b1}})) next_state = ST_READY;
            ST_READY: if (swap_req) next_state = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == '0) next_state = ST_LOAD;
            default:  next_state = ST_LOAD;
        endcase
    end

    // Handshake-qualified outputs are registered so the LUT sees a clean write one cycle later.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state            <= ST_LOAD;
            wr_cnt           <= '0;
            drain_cnt        <= '0;
            read_addr_offset <= 1'b0;
            we               <= 1'b0;
            page_write_addr  <= '0;
            lut_in_bank0     <= '0;
            lut_in_bank1     <= '0;
            swap_ack         <= 1'b0;
            shadow_valid     <= 1'b0;
            in_ready         <= 1'b0;
        end else begin
            state        <= next_state;
            we           <= hs;
            swap_ack     <= 1'b0;
            in_ready     <= (next_state == ST_LOAD);
            shadow_valid <= (next_state == ST_READY);

            if (hs) begin
                page_write_addr <= wr_cnt;
                lut_in_bank0    <= in_bank0;
                lut_in_bank1    <= in_bank1;
                wr_cnt          <= wr_cnt + 1'b1;
            end

            if (state == ST_READY && swap_req) begin
                read_addr_offset <= ~read_addr_offset;
                swap_ack         <= 1'b1;
                drain_cnt        <= DRAIN_LOAD;
            end else if (state == ST_DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
        end
    end

endmodule
